// File: rtl/seq_det_pkg.sv
// Shared constants, width helper and config record for the parametrised
// serial pattern detector.
package seq_det_pkg;

    localparam int                  DEF_PAT_W       = 8;
    localparam int                  DEF_CNT_W       = 16;
    localparam logic [DEF_PAT_W-1:0] DEF_RST_PATTERN = 8'b0000_1010;
    localparam int                  DEF_RST_LEN     = 4;
    localparam logic                DEF_RST_OVERLAP = 1'b1;

    // Width needed to hold a pattern length in 0..pat_w.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    localparam int DEF_LEN_W = len_w(DEF_PAT_W);

    // Active detector configuration at the default geometry.
    typedef struct packed {
        logic [DEF_PAT_W-1:0] pat;
        logic [DEF_LEN_W-1:0] len;
        logic                 ovl;
    } seq_cfg_t;

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with a sticky saturation flag; clear beats increment.
module seq_match_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;
    logic             sat_r;

    // Count matches, hold at all-ones, and flag the moment all-ones is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            sat_r   <= sat_r | (count_r == (CNT_MAX - {{(CNT_W-1){1'b0}}, 1'b1}));
        end else begin
            count_r <= count_r;
            sat_r   <= sat_r;
        end
    end

    assign count = count_r;
    assign sat   = sat_r;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector: shadow config, history
// shifter with fill tracking, masked compare and a saturating match counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = DEF_PAT_W,
    parameter int               CNT_W       = DEF_CNT_W,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(DEF_RST_PATTERN),
    parameter int               RST_LEN     = DEF_RST_LEN,
    parameter logic             RST_OVERLAP = DEF_RST_OVERLAP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    input  logic                      i_bit,
    input  logic                      cfg_load,
    input  logic [PAT_W-1:0]          cfg_pattern,
    input  logic [len_w(PAT_W)-1:0]   cfg_len,
    input  logic                      cfg_overlap,
    input  logic                      clr_count,
    output logic                      flag,
    output logic [CNT_W-1:0]          match_count,
    output logic                      count_sat
);

    localparam int             LW        = len_w(PAT_W);
    localparam logic [LW-1:0]  PAT_W_L   = LW'(PAT_W);
    localparam logic [LW-1:0]  RST_LEN_L = (RST_LEN > PAT_W) ? PAT_W_L : LW'(RST_LEN);

    logic [PAT_W-1:0] pat_r;
    logic [LW-1:0]    len_r;
    logic             ovl_r;
    logic [PAT_W-1:0] hist_r;
    logic [LW-1:0]    fill_r;
    logic             flag_r;

    logic [PAT_W-1:0] hist_next_s;
    logic [LW-1:0]    fill_inc_s;
    logic [PAT_W-1:0] mask_s;
    logic [LW-1:0]    len_clamped_s;
    logic             sample_s;
    logic             match_s;

    // Next history/fill after a sample, compare mask for the active length,
    // and the match decision. A load in the same cycle discards the bit.
    always_comb begin
        hist_next_s = {hist_r[PAT_W-2:0], i_bit};
        if (fill_r == PAT_W_L) begin
            fill_inc_s = fill_r;
        end else begin
            fill_inc_s = fill_r + {{(LW-1){1'b0}}, 1'b1};
        end
        mask_s = {PAT_W{1'b0}};
        for (int i = 0; i < PAT_W; i++) begin
            mask_s[i] = (LW'(i) < len_r);
        end
        if (cfg_len > PAT_W_L) begin
            len_clamped_s = PAT_W_L;
        end else begin
            len_clamped_s = cfg_len;
        end
        sample_s = i_valid & ~cfg_load;
        match_s  = sample_s
                 && (len_r != {LW{1'b0}})
                 && (fill_inc_s >= len_r)
                 && (((hist_next_s ^ pat_r) & mask_s) == {PAT_W{1'b0}});
    end

    // Config shadow, history shifter, fill tracking and registered match pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r  <= RST_PATTERN;
            len_r  <= RST_LEN_L;
            ovl_r  <= RST_OVERLAP;
            hist_r <= {PAT_W{1'b0}};
            fill_r <= {LW{1'b0}};
            flag_r <= 1'b0;
        end else if (cfg_load) begin
            pat_r  <= cfg_pattern;
            len_r  <= len_clamped_s;
            ovl_r  <= cfg_overlap;
            hist_r <= {PAT_W{1'b0}};
            fill_r <= {LW{1'b0}};
            flag_r <= 1'b0;
        end else if (i_valid) begin
            hist_r <= hist_next_s;
            flag_r <= match_s;
            if (match_s && !ovl_r) begin
                fill_r <= {LW{1'b0}};
            end else begin
                fill_r <= fill_inc_s;
            end
        end else begin
            flag_r <= 1'b0;
        end
    end

    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match_s),
        .clr   (clr_count),
        .count (match_count),
        .sat   (count_sat)
    );

    assign flag = flag_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus a randomized stretch,
// checked every cycle against a queue-based reference of the matching rules.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid, i_bit, cfg_load, cfg_overlap, clr_count;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic        flag_a, flag_b, sat_a, sat_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;

    int errors = 0;
    int checks = 0;
    int hits   = 0;

    // Reference state
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         q[$];
    bit         e_flag;
    int         e_cnt_a, e_cnt_b;
    bit         e_sat_a, e_sat_b;

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_bit(i_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .flag(flag_a), .match_count(cnt_a), .count_sat(sat_a));

    seq_detect_param #(.PAT_W(8), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_bit(i_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .clr_count(clr_count),
        .flag(flag_b), .match_count(cnt_b), .count_sat(sat_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = 8'b0000_1010; m_len = 4; m_ovl = 1'b1;
        q.delete();
        e_flag = 1'b0;
        e_cnt_a = 0; e_cnt_b = 0; e_sat_a = 1'b0; e_sat_b = 1'b0;
    endtask

    task automatic check_all();
        chk("flag_a", 32'(flag_a), 32'(e_flag));
        chk("flag_b", 32'(flag_b), 32'(e_flag));
        chk("cnt_a",  32'(cnt_a),  32'(e_cnt_a));
        chk("cnt_b",  32'(cnt_b),  32'(e_cnt_b));
        chk("sat_a",  32'(sat_a),  32'(e_sat_a));
        chk("sat_b",  32'(sat_b),  32'(e_sat_b));
    endtask

    // One clock cycle: drive at negedge, update reference, check after posedge.
    task automatic drive(input bit v, input bit b, input bit ld, input logic [7:0] p,
                         input int l, input bit o, input bit clr);
        bit hit;
        i_valid = v; i_bit = b; cfg_load = ld; cfg_pattern = p;
        cfg_len = 4'(l); cfg_overlap = o; clr_count = clr;
        hit = 1'b0;
        if (ld) begin
            m_pat = p; m_len = (l > 8) ? 8 : l; m_ovl = o;
            q.delete();
            e_flag = 1'b0;
        end else if (v) begin
            q.push_back(b);
            if (q.size() > 8) void'(q.pop_front());
            if (m_len > 0 && q.size() >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
            end
            e_flag = hit;
            if (hit && !m_ovl) q.delete();
        end else begin
            e_flag = 1'b0;
        end
        if (clr) begin
            e_cnt_a = 0; e_cnt_b = 0; e_sat_a = 1'b0; e_sat_b = 1'b0;
        end else if (hit) begin
            if (e_cnt_a < 65535) e_cnt_a++;
            if (e_cnt_a == 65535) e_sat_a = 1'b1;
            if (e_cnt_b < 7) e_cnt_b++;
            if (e_cnt_b == 7) e_sat_b = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all();
        if (flag_a === 1'b1) hits++;
        @(negedge clk);
    endtask

    task automatic bitin(input bit b);
        drive(1'b1, b, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input int l, input bit o);
        drive(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
    endtask

    task automatic clear();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
    endtask

    // Asynchronous reset pulse starting mid-cycle, released on a later negedge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        i_valid = 1'b0; i_bit = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pat8;
        int         h0;
        rst_n = 1'b1;
        @(negedge clk);
        pulse_reset();

        // Defaults, overlapping 1010
        for (int i = 0; i < 6; i++) bitin(i % 2 == 0);
        chk("ovl_count", 32'(cnt_a), 32'd2);

        // Non-overlapping 1010
        clear();
        load(8'b0000_1010, 4, 1'b0);
        for (int i = 0; i < 6; i++) bitin(i % 2 == 0);
        chk("novl_count", 32'(cnt_a), 32'd1);

        // Full-width pattern with random prefix and valid gaps
        pat8 = 8'b1100_1011;
        load(pat8, 8, 1'b1);
        h0 = hits;
        for (int i = 0; i < 3; i++) bitin(1'($urandom));
        for (int i = 7; i >= 0; i--) begin
            bitin(pat8[i]);
            if (i == 5 || i == 2) begin idle(); idle(); end
        end
        chk("len8_last_flag", 32'(flag_a), 32'd1);
        idle();
        chk("len8_hits", 32'(hits - h0), 32'd1);

        // len=0 never matches
        load(8'h00, 0, 1'b1);
        h0 = hits;
        for (int i = 0; i < 100; i++) bitin(1'($urandom));
        chk("len0_hits", 32'(hits - h0), 32'd0);

        // len=12 clamps to 8
        pat8 = 8'hA5;
        load(pat8, 12, 1'b1);
        for (int i = 7; i >= 0; i--) bitin(pat8[i]);
        chk("clamp_flag", 32'(flag_a), 32'd1);

        // Saturation of the narrow counter, then clear against a match
        clear();
        load(8'b0000_0011, 2, 1'b1);
        for (int i = 0; i < 10; i++) bitin(1'b1);
        chk("sat_cnt_b", 32'(cnt_b), 32'd7);
        chk("sat_b_set", 32'(sat_b), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
        chk("clr_match_flag", 32'(flag_a), 32'd1);
        chk("clr_match_cnt", 32'(cnt_b), 32'd0);
        chk("clr_match_sat", 32'(sat_b), 32'd0);

        // Reset mid-stream discards partial history
        bitin(1'b1); bitin(1'b0); bitin(1'b1);
        pulse_reset();
        bitin(1'b0);
        chk("rst_no_flag", 32'(flag_a), 32'd0);

        // Load coincident with a valid bit drops that bit
        drive(1'b1, 1'b1, 1'b1, 8'b0000_1010, 4, 1'b1, 1'b0);
        h0 = hits;
        bitin(1'b0); bitin(1'b1); bitin(1'b0);
        chk("load_drop_hits", 32'(hits - h0), 32'd0);

        // Randomized stretch
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0)
                drive(1'($urandom), 1'($urandom), 1'b1, 8'($urandom),
                      $urandom_range(0, 12), 1'($urandom), 1'b0);
            else
                drive($urandom_range(0, 3) != 0, 1'($urandom), 1'b0, 8'h00, 0, 1'b0,
                      $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
